famicom_cpu_bus_master: RTL and testbench

- Bus initiator for the Famicom cartridge CPU port: generates a free-running M2 and drives ROMSEL, R/W, A14..A0 and D7..D0 the way a 2A03 does.
- Used in the bench FPGA and the cartridge dumper/programmer to exercise the cartridge: mapper register writes, flash/SRAM access and M2-counted power-on logic.
- A host issues single-byte read/write requests over a valid/ready handshake; each request becomes exactly one M2 cycle.
- With no request pending, the block runs idle read cycles so M2 never stalls unless `run` is low.

---
 rtl/famicom_bus_pkg.sv | 25 ++
 rtl/famicom_irq_sync.sv | 24 ++
 rtl/famicom_cpu_bus_master.sv | 141 ++++++++++++++
 tb/tb_famicom_cpu_bus_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/famicom_bus_pkg.sv
// Shared types and default timing for the Famicom CPU-port bus master.
package famicom_bus_pkg;

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } bus_state_e;

  localparam int unsigned DEF_M2_LOW_CLKS  = 4;
  localparam int unsigned DEF_M2_HIGH_CLKS = 5;
  localparam int unsigned DEF_WDATA_DELAY  = 1;
  localparam logic [15:0] DEF_IDLE_ADDR    = 16'hFFFF;

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
  } bus_req_t;

  function automatic bus_req_t idle_req(input logic [15:0] addr);
    return '{addr: addr, rw: 1'b1, wdata: 8'h00};
  endfunction

endpackage

// File: rtl/famicom_irq_sync.sv
// Two-flop synchronizer for asynchronous cartridge/PPU-side status lines.
module famicom_irq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/famicom_cpu_bus_master.sv
// Famicom cartridge CPU-port initiator: free-running M2 with one host request
// (or an idle read) per M2 cycle, 2A03-style ROMSEL/R/W/address/data timing.
module famicom_cpu_bus_master
  import famicom_bus_pkg::*;
#(
  parameter int unsigned M2_LOW_CLKS  = DEF_M2_LOW_CLKS,
  parameter int unsigned M2_HIGH_CLKS = DEF_M2_HIGH_CLKS,
  parameter int unsigned WDATA_DELAY  = DEF_WDATA_DELAY,
  parameter logic [15:0] IDLE_ADDR    = DEF_IDLE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_rw,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        irq_n,
  output logic        irq_sync,
  output logic [31:0] m2_cycles
);

  localparam logic [3:0] LOW_LAST  = 4'(M2_LOW_CLKS - 1);
  localparam logic [3:0] HIGH_LAST = 4'(M2_HIGH_CLKS - 1);
  localparam logic [3:0] WD_PH     = 4'(WDATA_DELAY);

  bus_state_e st_q, st_d;
  logic [3:0] ph_q, ph_d;
  logic       fresh_q;
  bus_req_t   cyc_q;
  bus_req_t   req_in;
  logic       cyc_host_q;
  logic       last_high;
  logic       accept;
  logic       nxt_high;
  logic       oe_d;
  logic       host_read_done;
  logic       irq_asserted;

  assign req_in    = '{addr: req_addr, rw: req_rw, wdata: req_wdata};
  assign last_high = (st_q == S_HIGH) && (ph_q == HIGH_LAST);
  // Cycle start coincides with req_ready: an accept latches the host request,
  // otherwise the same edge latches an idle read.
  assign req_ready = run && (last_high || (st_q == S_STOP));
  assign accept    = req_valid && req_ready;

  assign cpu_rw   = cyc_q.rw;
  assign cpu_addr = cyc_q.addr[14:0];

  always_comb begin
    st_d = st_q;
    ph_d = ph_q + 4'd1;
    unique case (st_q)
      S_STOP: begin
        ph_d = '0;
        if (run) st_d = S_LOW;
      end
      S_LOW: begin
        // Out of reset the block sits in LOW; with run low it parks instead.
        if (fresh_q && !run) begin
          st_d = S_STOP;
          ph_d = '0;
        end else if (ph_q == LOW_LAST) begin
          st_d = S_HIGH;
          ph_d = '0;
        end
      end
      S_HIGH: begin
        if (ph_q == HIGH_LAST) begin
          st_d = run ? S_LOW : S_STOP;
          ph_d = '0;
        end
      end
      default: begin
        st_d = S_STOP;
        ph_d = '0;
      end
    endcase
  end

  assign nxt_high       = (st_d == S_HIGH);
  // Write data is held one clk past the M2 fall.
  assign oe_d           = !cyc_q.rw && ((nxt_high && (ph_d >= WD_PH)) || last_high);
  assign host_read_done = last_high && cyc_host_q && cyc_q.rw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= S_LOW;
      ph_q         <= '0;
      fresh_q      <= 1'b1;
      m2           <= 1'b0;
      romsel       <= 1'b1;
      cpu_data_oe  <= 1'b0;
      cpu_data_out <= 8'h00;
      cyc_q        <= idle_req(IDLE_ADDR);
      cyc_host_q   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      m2_cycles    <= '0;
    end else begin
      st_q        <= st_d;
      ph_q        <= ph_d;
      fresh_q     <= 1'b0;
      m2          <= nxt_high;
      romsel      <= ~(nxt_high && cyc_q.addr[15]);
      cpu_data_oe <= oe_d;
      if (nxt_high && !cyc_q.rw) cpu_data_out <= cyc_q.wdata;

      if (req_ready) begin
        cyc_q      <= accept ? req_in : idle_req(IDLE_ADDR);
        cyc_host_q <= accept;
      end else if (st_d == S_STOP) begin
        cyc_q.rw <= 1'b1;
      end

      rsp_valid <= host_read_done;
      if (host_read_done) rsp_data <= cpu_data_in;
      if (last_high) m2_cycles <= m2_cycles + 32'd1;
    end
  end

  assign irq_asserted = ~irq_n;

  famicom_irq_sync u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_asserted),
    .q     (irq_sync)
  );

endmodule

// File: tb/tb_famicom_cpu_bus_master.sv
// Bench for famicom_cpu_bus_master: directed steps plus a randomized stretch,
// checked each clk against a time-offset model of the M2 bus cycle.
module tb_famicom_cpu_bus_master;

  localparam int L   = 4;
  localparam int H   = 5;
  localparam int WD  = 1;
  localparam int CYC = L + H;
  localparam logic [15:0] IDLE = 16'hFFFF;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_rw;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic        irq_n;
  logic        irq_sync;
  logic [31:0] m2_cycles;

  famicom_cpu_bus_master #(
    .M2_LOW_CLKS  (L),
    .M2_HIGH_CLKS (H),
    .WDATA_DELAY  (WD),
    .IDLE_ADDR    (IDLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_rw       (req_rw),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .m2           (m2),
    .romsel       (romsel),
    .cpu_rw       (cpu_rw),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_data_oe  (cpu_data_oe),
    .cpu_data_in  (cpu_data_in),
    .irq_n        (irq_n),
    .irq_sync     (irq_sync),
    .m2_cycles    (m2_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
  } treq_t;

  treq_t pend[$];
  int    vectors;
  int    miscompares;
  bit    fix_bus;

  // Reference model: either parked, or at offset m_o (0..CYC-1) into a bus cycle.
  bit          m_stop;
  int          m_o;
  logic [15:0] m_addr;
  logic        m_rw;
  logic [7:0]  m_wdata;
  bit          m_host;
  bit          m_hold;
  logic [7:0]  m_hold_data;
  bit          m_rsp;
  logic [7:0]  m_rsp_data;
  logic [31:0] m_cnt;
  bit          h0, h1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stop = !run; m_o = 0; m_addr = IDLE; m_rw = 1'b1; m_wdata = 8'h00; m_host = 0;
    m_hold = 0; m_hold_data = 8'h00; m_rsp = 0; m_rsp_data = 8'h00; m_cnt = 0; h0 = 0; h1 = 0;
  endtask

  task automatic model_clk();
    bit rr;
    rr = run && (m_stop || m_o == CYC - 1);
    h1 = h0;
    h0 = ~irq_n;
    m_rsp = 0;
    m_hold = 0;
    if (!m_stop && m_o == CYC - 1) begin
      m_cnt++;
      if (m_host && m_rw) begin m_rsp = 1; m_rsp_data = cpu_data_in; end
      if (!m_rw) begin m_hold = 1; m_hold_data = m_wdata; end
    end
    if (rr) begin
      m_stop = 0;
      m_o = 0;
      if (req_valid) begin
        m_addr = req_addr; m_rw = req_rw; m_wdata = req_wdata; m_host = 1;
        void'(pend.pop_front());
      end else begin
        m_addr = IDLE; m_rw = 1'b1; m_host = 0;
      end
    end else if (!m_stop) begin
      if (m_o == CYC - 1) m_stop = 1;
      else m_o++;
    end
  endtask

  task automatic check();
    bit in_hi, exp_oe;
    in_hi  = !m_stop && m_o >= L;
    exp_oe = m_hold || (!m_stop && !m_rw && m_o >= L + WD);
    chk("m2", 32'(m2), 32'(in_hi));
    chk("romsel", 32'(romsel), 32'(!(in_hi && m_addr[15])));
    chk("cpu_rw", 32'(cpu_rw), 32'(m_stop ? 1'b1 : m_rw));
    if (!m_stop) chk("cpu_addr", 32'(cpu_addr), 32'(m_addr[14:0]));
    chk("cpu_data_oe", 32'(cpu_data_oe), 32'(exp_oe));
    if (exp_oe) chk("cpu_data_out", 32'(cpu_data_out), 32'(m_hold ? m_hold_data : m_wdata));
    chk("req_ready", 32'(req_ready), 32'(run && (m_stop || m_o == CYC - 1)));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    if (m_rsp) chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
    chk("irq_sync", 32'(irq_sync), 32'(h1));
    chk("m2_cycles", m2_cycles, m_cnt);
  endtask

  task automatic check_reset();
    chk("rst_m2", 32'(m2), 32'd0);
    chk("rst_romsel", 32'(romsel), 32'd1);
    chk("rst_cpu_rw", 32'(cpu_rw), 32'd1);
    chk("rst_cpu_addr", 32'(cpu_addr), 32'h7FFF);
    chk("rst_oe", 32'(cpu_data_oe), 32'd0);
    chk("rst_data_out", 32'(cpu_data_out), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_irq_sync", 32'(irq_sync), 32'd0);
    chk("rst_m2_cycles", m2_cycles, 32'd0);
  endtask

  // One clk: drive inputs at the falling edge, check, then advance the model.
  task automatic step();
    if (pend.size() > 0) begin
      req_valid = 1'b1; req_addr = pend[0].addr; req_rw = pend[0].rw; req_wdata = pend[0].wdata;
    end else begin
      req_valid = 1'b0; req_addr = 16'($urandom); req_rw = 1'($urandom); req_wdata = 8'($urandom);
    end
    cpu_data_in = fix_bus ? 8'h3C : 8'($urandom);
    #1;
    check();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pend.size() > 0 && n < budget) begin step(); n++; end
    if (pend.size() > 0) begin
      miscompares++;
      $error("FAIL drain: observed %0d queued expected 0", pend.size());
      pend.delete();
    end
  endtask

  task automatic run_to_phase(input int o, input bit need_write, input int budget);
    int n;
    n = 0;
    while (!(!m_stop && m_o == o && (!need_write || (m_host && !m_rw))) && n < budget) begin
      step(); n++;
    end
    if (n == budget) begin
      miscompares++;
      $error("FAIL wait_phase: observed offset %0d expected %0d", m_o, o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0; miscompares = 0; fix_bus = 0;
    rst_n = 1'b0; run = 1'b1; req_valid = 1'b0; req_addr = 16'h0000; req_rw = 1'b1;
    req_wdata = 8'h00; cpu_data_in = 8'h00; irq_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;

    // Idle cycles only: 10 complete M2 cycles in 90 clks.
    repeat (90) step();
    chk("m2_cycles_after_90", m2_cycles, 32'd10);

    // Write $8000 <- $A5.
    pend.push_back('{addr: 16'h8000, rw: 1'b0, wdata: 8'hA5});
    drain(3 * CYC);
    repeat (CYC + 2) step();

    // Read $6000 with the bus returning $3C.
    fix_bus = 1;
    pend.push_back('{addr: 16'h6000, rw: 1'b1, wdata: 8'h00});
    drain(3 * CYC);
    repeat (CYC + 2) step();
    fix_bus = 0;

    // Four back-to-back requests.
    pend.push_back('{addr: 16'h8123, rw: 1'b1, wdata: 8'h00});
    pend.push_back('{addr: 16'h6001, rw: 1'b0, wdata: 8'h5A});
    pend.push_back('{addr: 16'hC000, rw: 1'b1, wdata: 8'h00});
    pend.push_back('{addr: 16'h8000, rw: 1'b0, wdata: 8'hFF});
    drain(6 * CYC);
    repeat (2 * CYC) step();

    // Drop run at HIGH clk 2 with a request waiting; it is taken from STOP.
    run_to_phase(L + 1, 1'b0, 2 * CYC);
    run = 1'b0;
    pend.push_back('{addr: 16'hE5A5, rw: 1'b1, wdata: 8'h00});
    repeat (CYC + 12) step();
    run = 1'b1;
    drain(3 * CYC);
    repeat (2 * CYC) step();

    // Randomized traffic with run and irq_n toggling.
    for (int i = 0; i < 1500; i++) begin
      if (pend.size() < 2 && $urandom_range(0, 3) == 0)
        pend.push_back('{addr: 16'($urandom), rw: 1'($urandom), wdata: 8'($urandom)});
      if ($urandom_range(0, 99) == 0) run = ~run;
      if ($urandom_range(0, 19) == 0) irq_n = ~irq_n;
      step();
    end
    run = 1'b1;
    irq_n = 1'b1;
    drain(6 * CYC);
    repeat (2 * CYC) step();

    // Asynchronous reset in the middle of a write's HIGH phase.
    pend.push_back('{addr: 16'h8000, rw: 1'b0, wdata: 8'hC3});
    run_to_phase(L + 2, 1'b1, 4 * CYC);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    pend.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    check_reset();
    model_reset();
    rst_n = 1'b1;
    repeat (2 * CYC) step();

    // irq_n low for 3 clks.
    irq_n = 1'b0;
    repeat (3) step();
    irq_n = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
